// File: rtl/wb_spram_pkg.sv
// Shared types and helpers for the pipelined
// Wishbone single-port RAM slave (no ports).
package wb_spram_pkg;

  localparam int MAX_LATENCY = 3;

  typedef enum logic [1:0] {
    IDLE_RST,
    SWEEP,
    READY
  } init_state_e;

  function automatic int off_bits(input int dw);
    return $clog2(dw / 8);
  endfunction

  function automatic int adr_bits(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sp_ram_be.sv
// Inferred single-port RAM, byte write enables, one-cycle registered read.
// Ports: clk, we, be (lanes), addr (word), d (write data), q (read data).
module sp_ram_be
  import wb_spram_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 16384,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [DW/8-1:0] be,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   d,
  output logic [DW-1:0]   q
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < DW / 8; b++) begin
      if (we && be[b]) begin
        mem[addr][b*8 +: 8] <= d[b*8 +: 8];
      end
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/wb_spram_pipe.sv
// Pipelined Wishbone RAM slave: byte lanes, err on out-of-range, optional zero sweep.
// Ports: clk, rst (sync, low), wb_* slave bus, init_done (memory usable).
module wb_spram_pipe
  import wb_spram_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 16384,
  parameter int BUS_ADR_WIDTH = 32,
  parameter int LATENCY       = 1,
  parameter bit INIT_ZERO     = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_cyc,
  input  logic                     wb_stb,
  input  logic                     wb_we,
  input  logic [BUS_ADR_WIDTH-1:0] wb_adr,
  input  logic [DATA_WIDTH/8-1:0]  wb_sel,
  input  logic [DATA_WIDTH-1:0]    wb_dat_i,
  output logic [DATA_WIDTH-1:0]    wb_dat_o,
  output logic                     wb_ack,
  output logic                     wb_err,
  output logic                     wb_stall,
  output logic                     init_done
);

  localparam int OFF = off_bits(DATA_WIDTH);
  localparam int AW  = adr_bits(DEPTH);
  localparam int SW  = DATA_WIDTH / 8;
  localparam int LAT =
    (LATENCY < 1) ? 1 :
    (LATENCY > MAX_LATENCY) ? MAX_LATENCY :
    LATENCY;

  logic [AW-1:0] wi;
  logic          oor;
  logic          acc;
  logic          wr_acc;
  logic          adr_unused;

  init_state_e   state;
  init_state_e   state_n;
  logic [AW-1:0] cnt;
  logic [AW-1:0] cnt_n;
  logic          sweep_we;

  logic          ram_we;
  logic [SW-1:0] ram_be;
  logic [AW-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_d;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [DATA_WIDTH-1:0] dout;

  logic [LAT-1:0] vld;
  logic [LAT-1:0] err_p;
  logic [LAT-1:0] rd_p;

  assign wi = wb_adr[OFF+AW-1:OFF];
  // Lane-offset bits are ignored.
  assign adr_unused = ^wb_adr;

  if (BUS_ADR_WIDTH > OFF + AW) begin : g_hi
    assign oor = |wb_adr[BUS_ADR_WIDTH-1:OFF+AW];
  end else begin : g_nohi
    assign oor = 1'b0;
  end

  assign wb_stall  = (state != READY);
  assign init_done = (state == READY);

  assign acc    = rst & wb_cyc & wb_stb & ~wb_stall;
  assign wr_acc = acc & wb_we & ~oor;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= INIT_ZERO ? IDLE_RST : READY;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // IDLE_RST already clears word 0 so the
  // sweep finishes DEPTH cycles after reset.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    sweep_we = 1'b0;
    unique case (state)
      IDLE_RST: begin
        sweep_we = 1'b1;
        cnt_n    = cnt + AW'(1);
        state_n  = SWEEP;
      end
      SWEEP: begin
        sweep_we = 1'b1;
        cnt_n    = cnt + AW'(1);
        if (cnt == AW'(DEPTH - 1)) begin
          state_n = READY;
        end
      end
      READY: begin
        state_n = READY;
      end
      default: begin
        state_n = READY;
      end
    endcase
  end

  // Reset holds IDLE_RST; its write waits
  // for rst to be released.
  always_comb begin
    ram_we   = wr_acc;
    ram_be   = wb_sel;
    ram_addr = wi;
    ram_d    = wb_dat_i;
    if (sweep_we) begin
      ram_we   = rst;
      ram_be   = '1;
      ram_addr = cnt;
      ram_d    = '0;
    end
  end

  sp_ram_be #(
    .DW    (DATA_WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .be   (ram_be),
    .addr (ram_addr),
    .d    (ram_d),
    .q    (ram_q)
  );

  always_ff @(posedge clk) begin
    if (!rst || !wb_cyc) begin
      vld   <= '0;
      err_p <= '0;
      rd_p  <= '0;
    end else begin
      vld   <= (vld << 1) | LAT'(acc);
      err_p <= (err_p << 1) | LAT'(acc & oor);
      rd_p  <= (rd_p << 1)
             | LAT'(acc & ~wb_we & ~oor);
    end
  end

  if (LAT == 1) begin : g_dir
    assign dout = ram_q;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] dreg [LAT-1];
    always_ff @(posedge clk) begin
      dreg[0] <= ram_q;
      for (int k = 1; k < LAT - 1; k++) begin
        dreg[k] <= dreg[k-1];
      end
    end
    assign dout = dreg[LAT-2];
  end

  assign wb_ack   = vld[LAT-1] & ~err_p[LAT-1];
  assign wb_err   = vld[LAT-1] & err_p[LAT-1];
  assign wb_dat_o = rd_p[LAT-1] ? dout : '0;

endmodule

// File: tb/tb_wb_spram_pipe.sv
// Bench for wb_spram_pipe: three instances (lat 1, lat 3,
// zero-init depth 16) on one shared bus against a reference model.
module tb_wb_spram_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_i;
  logic [2:0]  ack;
  logic [2:0]  err;
  logic [2:0]  stall;
  logic [2:0]  done;
  logic [31:0] dat [3];

  int total  = 0;
  int passes = 0;
  int cyc_n  = 0;
  int zc     = 0;

  typedef struct {
    int          due;
    bit          err;
    bit          rd;
    logic [31:0] data;
  } rsp_t;

  rsp_t q0[$];
  rsp_t q1[$];
  rsp_t q2[$];

  logic [31:0] mem_big [int];
  logic [31:0] mem_small [16];

  logic [31:0] pool [8] = '{
    32'h0000_0000, 32'h0000_0004,
    32'h0000_0010, 32'h0000_003C,
    32'h0000_0080, 32'h0000_0200,
    32'h0001_0000, 32'hFFFF_0004
  };

  wb_spram_pipe #(.LATENCY(1)) u0 (
    .clk(clk), .rst(rst), .wb_cyc(cyc),
    .wb_stb(stb), .wb_we(we), .wb_adr(adr),
    .wb_sel(sel), .wb_dat_i(dat_i),
    .wb_dat_o(dat[0]), .wb_ack(ack[0]),
    .wb_err(err[0]), .wb_stall(stall[0]),
    .init_done(done[0])
  );

  wb_spram_pipe #(.LATENCY(3)) u1 (
    .clk(clk), .rst(rst), .wb_cyc(cyc),
    .wb_stb(stb), .wb_we(we), .wb_adr(adr),
    .wb_sel(sel), .wb_dat_i(dat_i),
    .wb_dat_o(dat[1]), .wb_ack(ack[1]),
    .wb_err(err[1]), .wb_stall(stall[1]),
    .init_done(done[1])
  );

  wb_spram_pipe #(
    .DEPTH(16), .LATENCY(2), .INIT_ZERO(1'b1)
  ) uz (
    .clk(clk), .rst(rst), .wb_cyc(cyc),
    .wb_stb(stb), .wb_we(we), .wb_adr(adr),
    .wb_sel(sel), .wb_dat_i(dat_i),
    .wb_dat_o(dat[2]), .wb_ack(ack[2]),
    .wb_err(err[2]), .wb_stall(stall[2]),
    .init_done(done[2])
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h want %0h",
                tag, obs, exp);
  endtask

  function automatic logic [31:0] merge(
    input logic [31:0] o,
    input logic [31:0] n,
    input logic [3:0]  s);
    for (int b = 0; b < 4; b++)
      if (s[b]) o[8*b +: 8] = n[8*b +: 8];
    return o;
  endfunction

  task automatic pop_exp(input int d,
                         output logic a,
                         output logic e,
                         output logic [31:0] dv);
    rsp_t r;
    bit   hit;
    a = 1'b0; e = 1'b0; dv = '0; hit = 1'b0;
    case (d)
      0: if (q0.size() > 0 && q0[0].due == cyc_n)
           begin r = q0.pop_front(); hit = 1'b1; end
      1: if (q1.size() > 0 && q1[0].due == cyc_n)
           begin r = q1.pop_front(); hit = 1'b1; end
      default:
         if (q2.size() > 0 && q2[0].due == cyc_n)
           begin r = q2.pop_front(); hit = 1'b1; end
    endcase
    if (hit) begin
      a  = !r.err;
      e  = r.err;
      dv = r.rd ? r.data : 32'h0;
    end
  endtask

  // One clock: update the model from the request
  // presented before the edge, then check all outputs.
  task automatic step();
    bit          acc_b;
    bit          acc_z;
    rsp_t        r;
    int          wi;
    logic        ea;
    logic        ee;
    logic [31:0] ed;
    acc_b = rst && cyc && stb;
    acc_z = acc_b && (zc >= 16);
    @(posedge clk);
    cyc_n++;
    if (!rst) begin
      q0.delete(); q1.delete(); q2.delete();
      zc = 0;
    end else begin
      if (!cyc) begin
        q0.delete(); q1.delete(); q2.delete();
      end
      if (zc == 0)
        foreach (mem_small[i]) mem_small[i] = '0;
      if (zc < 16) zc++;
      if (acc_b) begin
        r = '{due: cyc_n, err: 1'b0, rd: 1'b0,
              data: 32'h0};
        if (adr >= 32'h0001_0000) r.err = 1'b1;
        else begin
          wi = int'(adr >> 2);
          if (we)
            mem_big[wi] = merge(
              mem_big.exists(wi) ? mem_big[wi] : 32'h0,
              dat_i, sel);
          else begin
            r.rd   = 1'b1;
            r.data = mem_big.exists(wi)
                   ? mem_big[wi] : 32'h0;
          end
        end
        q0.push_back(r);
        r.due = cyc_n + 2;
        q1.push_back(r);
      end
      if (acc_z) begin
        r = '{due: cyc_n + 1, err: 1'b0, rd: 1'b0,
              data: 32'h0};
        if (adr >= 32'd64) r.err = 1'b1;
        else begin
          wi = int'(adr >> 2);
          if (we)
            mem_small[wi] = merge(mem_small[wi],
                                  dat_i, sel);
          else begin
            r.rd   = 1'b1;
            r.data = mem_small[wi];
          end
        end
        q2.push_back(r);
      end
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      pop_exp(d, ea, ee, ed);
      chk($sformatf("ack%0d@%0d", d, cyc_n),
          32'(ack[d]), 32'(ea));
      chk($sformatf("err%0d@%0d", d, cyc_n),
          32'(err[d]), 32'(ee));
      chk($sformatf("dat%0d@%0d", d, cyc_n),
          dat[d], ed);
    end
    chk("stall0", 32'(stall[0]), 32'h0);
    chk("stall1", 32'(stall[1]), 32'h0);
    chk("done0", 32'(done[0]), 32'h1);
    chk("stallz", 32'(stall[2]), 32'(zc < 16));
    chk("donez", 32'(done[2]), 32'(zc >= 16));
  endtask

  task automatic drive(input bit c, input bit s,
                       input bit w,
                       input logic [31:0] a,
                       input logic [3:0] sl,
                       input logic [31:0] d);
    cyc = c; stb = s; we = w;
    adr = a; sel = sl; dat_i = d;
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [3:0] sl);
    drive(1'b1, 1'b1, 1'b1, a, sl, d);
    step();
  endtask

  task automatic rd(input logic [31:0] a);
    drive(1'b1, 1'b1, 1'b0, a, 4'h0, 32'h0);
    step();
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    step();
  endtask

  initial begin
    int          k;
    int          first;
    int          n;
    int          p;
    logic [31:0] acc_or;
    logic [31:0] got[$];

    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (3) step();
    rst = 1'b1;
    repeat (20) step();

    // 1: full write then read, latency 1
    wr(32'h10, 32'hDEADBEEF, 4'hF);
    chk("t1_wr_ack", 32'(ack[0]), 32'h1);
    chk("t1_wr_dat", dat[0], 32'h0);
    rd(32'h10);
    chk("t1_rd_ack", 32'(ack[0]), 32'h1);
    chk("t1_rd_dat", dat[0], 32'hDEADBEEF);

    // 2: single byte lane
    wr(32'h10, 32'h00AA0000, 4'h4);
    rd(32'h10);
    chk("t2_rd_dat", dat[0], 32'hDEAABEEF);
    repeat (3) idle();

    // 3: back-to-back reads, latency 3
    for (int i = 0; i < 8; i++)
      wr(32'h100 + 32'(4 * i), 32'hA500_0000 | 32'(i),
         4'hF);
    repeat (3) idle();
    first = -1;
    got.delete();
    for (int s = 0; s < 11; s++) begin
      if (s < 8) rd(32'h100 + 32'(4 * s));
      else idle();
      if (ack[1]) begin
        if (first < 0) first = s;
        got.push_back(dat[1]);
      end
    end
    chk("t3_first", 32'(first), 32'd2);
    chk("t3_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < got.size(); i++)
      chk($sformatf("t3_dat%0d", i), got[i],
          32'hA500_0000 | 32'(i));

    // 4: out-of-range write
    wr(32'h0, 32'h12345678, 4'hF);
    wr(32'h0001_0000, 32'hFFFFFFFF, 4'hF);
    chk("t4_err", 32'(err[0]), 32'h1);
    chk("t4_noack", 32'(ack[0]), 32'h0);
    rd(32'h0);
    chk("t4_rd_dat", dat[0], 32'h12345678);
    repeat (3) idle();

    // 5: abort two reads in flight
    rd(32'h100);
    rd(32'h104);
    n = 0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    for (int s = 0; s < 5; s++) begin
      step();
      n += int'(ack[1]) + int'(err[1]);
    end
    chk("t5_noresp", 32'(n), 32'h0);

    // random traffic over a small address pool
    for (int i = 0; i < 8; i++) wr(pool[i], $urandom, 4'hF);
    repeat (300) begin
      p = $urandom_range(0, 7);
      drive($urandom_range(0, 15) != 0,
            $urandom_range(0, 3) != 0,
            1'($urandom_range(0, 1)),
            pool[p] | 32'($urandom_range(0, 3)),
            4'($urandom), $urandom);
      step();
    end
    repeat (4) idle();

    // 6: zero sweep after reset, and restart
    for (int i = 0; i < 16; i++)
      wr(32'(4 * i), 32'hC0DE_0000 | 32'(i), 4'hF);
    rd(32'h8);
    repeat (3) idle();
    drive(1'b1, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    k = 0;
    while (stall[2] && k < 40) begin step(); k++; end
    chk("t6_sweep_len", 32'(k), 32'd16);
    chk("t6_done", 32'(done[2]), 32'h1);
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    repeat (5) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    k = 0;
    while (stall[2] && k < 40) begin step(); k++; end
    chk("t6_restart_len", 32'(k), 32'd16);
    n = 0;
    acc_or = '0;
    for (int s = 0; s < 18; s++) begin
      if (s < 16) rd(32'(4 * s));
      else idle();
      if (ack[2]) begin
        n++;
        acc_or |= dat[2];
      end
    end
    chk("t6_acks", 32'(n), 32'd16);
    chk("t6_zero", acc_or, 32'h0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
